i2c_eeprom_cmd_sequencer: RTL
=============================

Name: i2c_eeprom_cmd_sequencer

Overview:
- Host-side command sequencer sitting directly upstream of the I2C master that drives the 24C256 EEPROM.
- Collects a fixed-length burst of write bytes from the host, or accepts a read request, and packs them into the master's 256-bit data word with the 7-bit device address and 16-bit memory address.
- Handshakes the master through enable/done/err, retries on NACK, enforces the EEPROM write-cycle time, and streams read bytes back to the host.

Parameters:
- NBYTES, 16, bytes per transaction; legal range 1..32.
- DEV_ADDR, 7'h50, 7-bit EEPROM device address.
- MAX_RETRY, 3, retries after m_err before reporting failure.
- ACCEPT_TIMEOUT, 64, clk cycles allowed for the master to drop m_done after m_enable.
- WR_CYCLE_CLKS, 1000, post-write quiet time in clk cycles (tWR).

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command request
- cmd_ready  out  1  sequencer accepts command
- cmd_rw  in  1  0 = write, 1 = read
- cmd_addr  in  16  EEPROM memory address
- wr_valid  in  1  write byte valid
- wr_ready  out  1  write byte accepted
- wr_byte  in  8  write data byte
- rd_valid  out  1  read byte valid
- rd_ready  in  1  host accepts read byte
- rd_byte  out  8  read data byte
- busy  out  1  high in any state except IDLE
- err  out  1  sticky failure flag, cleared on next accepted command
- retry_cnt  out  2  retries used by the last command
- m_enable  out  1  to master enable
- m_rw  out  1  to master rw
- m_addr  out  7  to master addr
- m_port_addr_f  out  8  cmd_addr[15:8]
- m_port_addr_s  out  8  cmd_addr[7:0]
- m_data_in  out  256  packed write data
- m_done  in  1  master done; high when idle
- m_err  in  1  master NACK/error
- m_data_out  in  256  master read data

Behaviour:
- Reset values: all outputs 0, except m_addr = DEV_ADDR. State = IDLE. Byte index and counters are 0. Reset mid-operation aborts immediately, and m_enable drops asynchronously.
- Byte mapping, both directions: transfer byte k (k = 0 is first on the bus) occupies bits [8*(NBYTES-1-k)+7 : 8*(NBYTES-1-k)]. Bits above 8*NBYTES are driven 0.
- IDLE: cmd_ready = 1.
  - On cmd_valid, latch rw and addr, clear err and retry_cnt, and leave IDLE in the same cycle.
  - Write goes to FILL; read goes to LAUNCH.
- FILL: wr_ready = 1.
  - Each wr_valid & wr_ready stores wr_byte at index k and increments k.
  - After byte NBYTES-1, go to LAUNCH. cmd_valid is ignored here.
- LAUNCH: assert m_enable with m_rw, addresses and data stable, then go to WAIT_BUSY.
- WAIT_BUSY:
  - Hold m_enable until m_done = 0, then drop m_enable and go to WAIT_DONE.
  - If the wait reaches ACCEPT_TIMEOUT cycles, set err and go to IDLE.
- WAIT_DONE: on m_done rising (registered edge detect), go to CHECK.
- CHECK:
  - If m_err = 1 and retry_cnt < MAX_RETRY: increment retry_cnt, go to BACKOFF.
  - If m_err = 1 and retry_cnt = MAX_RETRY: set err, go to IDLE.
  - Otherwise, a write goes to WR_WAIT; a read latches m_data_out and goes to DRAIN with k = 0.
- BACKOFF: wait WR_CYCLE_CLKS cycles (EEPROM may be busy-NACKing), then go to LAUNCH with unchanged data.
- WR_WAIT: count WR_CYCLE_CLKS cycles, then go to IDLE. cmd_ready stays 0 throughout.
- DRAIN:
  - Present byte k with rd_valid = 1; advance k on rd_valid & rd_ready.
  - After the last byte, go to IDLE.
  - rd_byte is held stable while rd_valid = 1 and rd_ready = 0.
- m_port_addr_f, m_port_addr_s and m_rw change only in IDLE.

Optional Feature:
- Macro: I2C_SEQ_PAGE_CHECK_EN.
- Defined: in IDLE, a command with cmd_addr[5:0] + NBYTES > 64 (crosses a 64-byte EEPROM page) is accepted but immediately sets err and returns to IDLE. No master transaction and no FILL occur.
- Undefined: no check; the EEPROM wraps within the page.

Decomposition:
- Package i2c_seq_pkg holds the state enumeration, the byte-lane mapping function, and the EEPROM page size constant (64).
- One sub-module, i2c_seq_cycle_timer: loadable down-counter shared by ACCEPT_TIMEOUT, BACKOFF and WR_WAIT, with a one-cycle expire pulse.

Test Plan:
- Write burst:
  - Stimulus: cmd addr 16'h0100, bytes 0x00..0x0F, master model ACKs.
  - Required: m_data_in[127:120] = 0x00 and [7:0] = 0x0F; m_port_addr_f = 0x01 and m_port_addr_s = 0x00; busy for the full WR_WAIT; then cmd_ready = 1.
- Read burst:
  - Stimulus: read cmd 16'h0200, master returns m_data_out[127:0] = 0x0F0E..00.
  - Required: rd_byte sequence 0x0F, 0x0E, …, 0x00. Applying rd_ready = 0 for 5 cycles mid-stream holds the byte stable.
- Retry success: m_err on attempts 1–2, success on attempt 3 -> retry_cnt = 2, err = 0.
- Retry exhaustion: m_err on every attempt -> exactly 4 m_enable launches, err = 1, return to IDLE.
- Accept timeout: m_done held at 1 -> err = 1 after 64 cycles, m_enable = 0.
- Reset mid-operation and page check:
  - Reset asserted in FILL after 7 bytes -> all outputs at reset values; the next write collects all NBYTES bytes afresh.
  - With I2C_SEQ_PAGE_CHECK_EN defined, cmd addr 16'h003A -> err = 1 and no m_enable.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared types for the 24C256 command sequencer: FSM states, EEPROM page
// size and the byte-lane mapping used for both write packing and read unpacking.
package i2c_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_CHECK,
        S_BACKOFF,
        S_WR_WAIT,
        S_DRAIN
    } seq_state_e;

    localparam int PAGE_BYTES = 64;

    // LSB position of bus byte k inside the master's data word; byte 0 is
    // first on the wire and sits in the most significant used lane.
    function automatic int lane_lsb(input int nbytes, input int k);
        return 8 * (nbytes - 1 - k);
    endfunction

endpackage

// File: rtl/i2c_seq_cycle_timer.sv
// Loadable down-counter with a one-cycle expire pulse. A load always wins
// and cancels any countdown (and pending pulse) already in progress.
module i2c_seq_cycle_timer
    import i2c_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         expire_q, expire_d;

    // Next count: reload, or decrement toward zero and flag the last step.
    always_comb begin
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - 1'b1;
            expire_d = (cnt_q == W'(1));
        end
    end

    // Counter and pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: rtl/i2c_eeprom_cmd_sequencer.sv
// Host-side command sequencer for the 24C256 I2C master: collects a write
// burst or a read request, launches the master, retries on NACK, enforces
// tWR and streams read bytes back. Optional 64-byte page-crossing rejection
// is built when I2C_SEQ_PAGE_CHECK_EN is defined.
module i2c_eeprom_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int         NBYTES         = 16,
    parameter logic [6:0] DEV_ADDR       = 7'h50,
    parameter int         MAX_RETRY      = 3,
    parameter int         ACCEPT_TIMEOUT = 64,
    parameter int         WR_CYCLE_CLKS  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_rw,
    input  logic [15:0]  cmd_addr,
    input  logic         wr_valid,
    output logic         wr_ready,
    input  logic [7:0]   wr_byte,
    output logic         rd_valid,
    input  logic         rd_ready,
    output logic [7:0]   rd_byte,
    output logic         busy,
    output logic         err,
    output logic [1:0]   retry_cnt,
    output logic         m_enable,
    output logic         m_rw,
    output logic [6:0]   m_addr,
    output logic [7:0]   m_port_addr_f,
    output logic [7:0]   m_port_addr_s,
    output logic [255:0] m_data_in,
    input  logic         m_done,
    input  logic         m_err,
    input  logic [255:0] m_data_out
);

    localparam int         TMR_W = 16;
    localparam logic [5:0] KLAST = 6'(NBYTES - 1);

    seq_state_e   state_q, state_d;
    logic [5:0]   k_q, k_d;
    logic [255:0] data_q, data_d;
    logic [255:0] rd_buf_q, rd_buf_d;
    logic [7:0]   rd_byte_q, rd_byte_d;
    logic         err_q, err_d;
    logic [1:0]   retry_q, retry_d;
    logic         m_rw_q, m_rw_d;
    logic [7:0]   addr_f_q, addr_f_d;
    logic [7:0]   addr_s_q, addr_s_d;
    logic         m_done_q;
    logic         cmd_ready_q, cmd_ready_d;
    logic         wr_ready_q, wr_ready_d;
    logic         rd_valid_q, rd_valid_d;
    logic         busy_q, busy_d;
    logic         m_enable_q, m_enable_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;

    i2c_seq_cycle_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Next-state, datapath updates and registered-output decode.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        data_d    = data_q;
        rd_buf_d  = rd_buf_q;
        rd_byte_d = rd_byte_q;
        err_d     = err_q;
        retry_d   = retry_q;
        m_rw_d    = m_rw_q;
        addr_f_d  = addr_f_q;
        addr_s_d  = addr_s_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_ready_q && cmd_valid) begin
                    m_rw_d   = cmd_rw;
                    addr_f_d = cmd_addr[15:8];
                    addr_s_d = cmd_addr[7:0];
                    err_d    = 1'b0;
                    retry_d  = '0;
                    k_d      = '0;
                    state_d  = cmd_rw ? S_LAUNCH : S_FILL;
`ifdef I2C_SEQ_PAGE_CHECK_EN
                    // A burst that would wrap inside the EEPROM page is refused outright.
                    if (int'(cmd_addr[5:0]) + NBYTES > PAGE_BYTES) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
`endif
                end
            end
            S_FILL: begin
                if (wr_ready_q && wr_valid) begin
                    data_d[lane_lsb(NBYTES, int'(k_q)) +: 8] = wr_byte;
                    if (k_q == KLAST) begin
                        k_d     = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            S_LAUNCH: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!m_done) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_expire) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (m_done && !m_done_q) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (m_err) begin
                    if (int'(retry_q) < MAX_RETRY) begin
                        retry_d = retry_q + 2'd1;
                        state_d = S_BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (m_rw_q) begin
                    rd_buf_d  = m_data_out;
                    rd_byte_d = m_data_out[lane_lsb(NBYTES, 0) +: 8];
                    k_d       = '0;
                    state_d   = S_DRAIN;
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_BACKOFF: begin
                if (tmr_expire) state_d = S_LAUNCH;
            end
            S_WR_WAIT: begin
                if (tmr_expire) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (rd_valid_q && rd_ready) begin
                    if (k_q == KLAST) begin
                        k_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        k_d       = k_q + 6'd1;
                        rd_byte_d = rd_buf_q[lane_lsb(NBYTES, int'(k_q) + 1) +: 8];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        cmd_ready_d = (state_d == S_IDLE);
        wr_ready_d  = (state_d == S_FILL);
        rd_valid_d  = (state_d == S_DRAIN);
        busy_d      = (state_d != S_IDLE);
        m_enable_d  = (state_d == S_LAUNCH) || (state_d == S_WAIT_BUSY);

        // The shared timer is armed on entry to each timed state.
        tmr_load = (state_d != state_q) &&
                   ((state_d == S_WAIT_BUSY) || (state_d == S_BACKOFF) || (state_d == S_WR_WAIT));
        tmr_val  = (state_d == S_WAIT_BUSY) ? TMR_W'(ACCEPT_TIMEOUT) : TMR_W'(WR_CYCLE_CLKS);
    end

    // State, datapath and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            data_q      <= '0;
            rd_buf_q    <= '0;
            rd_byte_q   <= '0;
            err_q       <= 1'b0;
            retry_q     <= '0;
            m_rw_q      <= 1'b0;
            addr_f_q    <= '0;
            addr_s_q    <= '0;
            m_done_q    <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            m_enable_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            data_q      <= data_d;
            rd_buf_q    <= rd_buf_d;
            rd_byte_q   <= rd_byte_d;
            err_q       <= err_d;
            retry_q     <= retry_d;
            m_rw_q      <= m_rw_d;
            addr_f_q    <= addr_f_d;
            addr_s_q    <= addr_s_d;
            m_done_q    <= m_done;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            busy_q      <= busy_d;
            m_enable_q  <= m_enable_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign wr_ready      = wr_ready_q;
    assign rd_valid      = rd_valid_q;
    assign rd_byte       = rd_byte_q;
    assign busy          = busy_q;
    assign err           = err_q;
    assign retry_cnt     = retry_q;
    assign m_enable      = m_enable_q;
    assign m_rw          = m_rw_q;
    assign m_addr        = DEV_ADDR;
    assign m_port_addr_f = addr_f_q;
    assign m_port_addr_s = addr_s_q;
    assign m_data_in     = data_q;

endmodule
